// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 set-2 scan-code sequencer.
// Decodes make / break (F0) / extended (E0) byte sequences into one-cycle
// key_en strobes, tracks the held key and counts distinct presses in BCD.
// Optional feature macro: PS2_KEY_CTRL_TIMEOUT_EN (prefix-state idle timeout).
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       key_en,
  output logic [7:0] keycode,
  output logic       key_ext,
  output logic       key_held,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nx_s;
  logic       accept_s;
  logic       is_nul_s;
  logic       make_s;
  logic       brk_s;
  logic       ext_s;
  logic       hit_s;
  logic       timeout_s;

  logic       key_en_r;
  logic [7:0] keycode_r;
  logic       key_ext_r;
  logic       key_held_r;
  logic [7:0] press_cnt_r;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  // The block never stalls: it is ready exactly when out of reset.
  assign data_ready = rst;
  assign accept_s   = data_valid && data_ready;
  assign is_nul_s   = (data_in == 8'h00) || (data_in == 8'hFF);

`ifdef PS2_KEY_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] timer_r;

  // Timeout fires on the idle cycle that would bring the counter to the limit.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r != IDLE) && !accept_s && (timer_r == TO_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Idle-cycle counter for prefix states; cleared by any accepted byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_r <= '0;
    end else if (accept_s || (state_r == IDLE) || timeout_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end
`else
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT_CYCLES != 0);
  assign timeout_s        = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode and classification of the accepted byte.
  always_comb begin
    state_nx_s = state_r;
    make_s     = 1'b0;
    brk_s      = 1'b0;
    ext_s      = 1'b0;
    if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (data_in == 8'hE0) begin
            state_nx_s = EXT;
          end else if (data_in == 8'hF0) begin
            state_nx_s = BRK;
          end else if (is_nul_s) begin
            state_nx_s = IDLE;
          end else begin
            make_s = 1'b1;
          end
        end
        EXT: begin
          if (data_in == 8'hF0) begin
            state_nx_s = EXT_BRK;
          end else if (data_in == 8'hE0) begin
            state_nx_s = EXT;
          end else if (is_nul_s) begin
            state_nx_s = IDLE;
          end else begin
            make_s     = 1'b1;
            ext_s      = 1'b1;
            state_nx_s = IDLE;
          end
        end
        BRK: begin
          if (data_in == 8'hF0) begin
            state_nx_s = BRK;
          end else if (data_in == 8'hE0) begin
            state_nx_s = EXT_BRK;
          end else if (is_nul_s) begin
            state_nx_s = IDLE;
          end else begin
            brk_s      = 1'b1;
            state_nx_s = IDLE;
          end
        end
        EXT_BRK: begin
          if ((data_in == 8'hF0) || (data_in == 8'hE0)) begin
            state_nx_s = EXT_BRK;
          end else if (is_nul_s) begin
            state_nx_s = IDLE;
          end else begin
            brk_s      = 1'b1;
            ext_s      = 1'b1;
            state_nx_s = IDLE;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end else if (timeout_s) begin
      state_nx_s = IDLE;
    end else begin
      state_nx_s = state_r;
    end
  end

  // The byte names the key currently held (same code and same extension).
  assign hit_s = key_held_r && (data_in == keycode_r) && (ext_s == key_ext_r);

  // Key state, strobe and press counter; typematic repeats and stale
  // releases leave everything untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_en_r    <= 1'b0;
      keycode_r   <= 8'h00;
      key_ext_r   <= 1'b0;
      key_held_r  <= 1'b0;
      press_cnt_r <= 8'h00;
    end else begin
      key_en_r <= 1'b0;
      if (make_s && !hit_s) begin
        key_en_r    <= 1'b1;
        keycode_r   <= data_in;
        key_ext_r   <= ext_s;
        key_held_r  <= 1'b1;
        press_cnt_r <= bcd_inc(press_cnt_r);
      end else if (brk_s && hit_s) begin
        key_en_r   <= 1'b1;
        keycode_r  <= 8'h00;
        key_ext_r  <= 1'b0;
        key_held_r <= 1'b0;
      end else begin
        key_en_r <= 1'b0;
      end
    end
  end

  assign key_en    = key_en_r;
  assign keycode   = keycode_r;
  assign key_ext   = key_ext_r;
  assign key_held  = key_held_r;
  assign press_cnt = press_cnt_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Testbench for ps2_key_ctrl: scoreboard of expected strobes
// {keycode, key_ext, key_held, press_cnt}, checked on every key_en.
`timescale 1ns/1ps
module tb_ps2_key_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       key_en;
  logic [7:0] keycode;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  ps2_key_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .key_en     (key_en),
    .keycode    (keycode),
    .key_ext    (key_ext),
    .key_held   (key_held),
    .press_cnt  (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every strobe must match the oldest expected entry.
  always @(negedge clk) begin
    logic [17:0] e;
    logic [17:0] got;
    if (rst === 1'b1 && key_en !== 1'b0) begin
      checks++;
      got = {keycode, key_ext, key_held, press_cnt};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL strobe got kc=%h ext=%b held=%b cnt=%h required kc=%h ext=%b held=%b cnt=%h",
                   got[17:10], got[9], got[8], got[7:0], e[17:10], e[9], e[8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] kc, input logic x, input logic h, input logic [7:0] c);
    exp_q.push_back({kc, x, h, c});
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in    = b;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Let the pipeline settle, then all expected strobes must have appeared.
  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_strobes got=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_state(input string name, input logic [7:0] kc, input logic x,
                             input logic h, input logic [7:0] c);
    checks++;
    if ({keycode, key_ext, key_held, press_cnt} !== {kc, x, h, c}) begin
      errors++;
      $display("FAIL %s got kc=%h ext=%b held=%b cnt=%h required kc=%h ext=%b held=%b cnt=%h",
               name, keycode, key_ext, key_held, press_cnt, kc, x, h, c);
    end
  endtask

  task automatic test_reset();
    data_valid = 1'b0;
    data_in    = 8'h00;
    rst        = 1'b0;
    #12;
    checks++;
    if ({data_ready, key_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready_en got=%b required=00", {data_ready, key_en});
    end
    check_state("reset_outputs", 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (data_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got=%b required=1", data_ready);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    send_byte(8'h1C);
    push(8'h00, 1'b0, 1'b0, 8'h01);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("make_break");
    check_state("make_break_end", 8'h00, 1'b0, 1'b0, 8'h01);
  endtask

  task automatic test_typematic();
    do_reset();
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    check_state("typematic_held", 8'h1C, 1'b0, 1'b1, 8'h01);
    push(8'h00, 1'b0, 1'b0, 8'h01);
    send_byte(8'hF0);
    send_byte(8'h1C);
    drain("typematic");
    check_state("typematic_end", 8'h00, 1'b0, 1'b0, 8'h01);
  endtask

  task automatic test_extended();
    do_reset();
    push(8'h75, 1'b1, 1'b1, 8'h01);
    send_byte(8'hE0);
    send_byte(8'h75);
    // Non-extended release of an extended key is stale.
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext_make");
    check_state("ext_stale_release", 8'h75, 1'b1, 1'b1, 8'h01);
    push(8'h00, 1'b0, 1'b0, 8'h01);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    drain("ext_break");
    // Ignored filler bytes in IDLE.
    send_byte(8'h00);
    send_byte(8'hFF);
    drain("filler");
    check_state("ext_end", 8'h00, 1'b0, 1'b0, 8'h01);
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    push(8'h32, 1'b0, 1'b1, 8'h02);
    push(8'h00, 1'b0, 1'b0, 8'h02);
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'hF0);
    send_byte(8'h32);
    drain("back_to_back");
  endtask

  task automatic test_count_wrap();
    logic [7:0] codes [16];
    logic [7:0] bcd;
    int n;
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
              8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D};
    do_reset();
    for (int i = 1; i <= 100; i++) begin
      n   = i % 100;
      bcd = {4'(n / 10), 4'(n % 10)};
      push(codes[i % 16], 1'b0, 1'b1, bcd);
      push(8'h00, 1'b0, 1'b0, bcd);
      send_byte(codes[i % 16]);
      send_byte(8'hF0);
      send_byte(codes[i % 16]);
    end
    drain("count_wrap");
    check_state("count_wrap_end", 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid_prefix();
    do_reset();
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    send_byte(8'h1C);
    send_byte(8'hF0);
    drain("mid_prefix_pre");
    rst = 1'b0;
    #3;
    checks++;
    if ({data_ready, key_en} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_ready_en got=%b required=00", {data_ready, key_en});
    end
    check_state("mid_reset_outputs", 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    send_byte(8'h1C);
    drain("mid_prefix_post");
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hF0);
    repeat (16) @(posedge clk);
    #1;
`ifdef PS2_KEY_CTRL_TIMEOUT_EN
    push(8'h1C, 1'b0, 1'b1, 8'h01);
    send_byte(8'h1C);
    drain("timeout");
    check_state("timeout_end", 8'h1C, 1'b0, 1'b1, 8'h01);
`else
    send_byte(8'h1C);
    drain("no_timeout");
    check_state("no_timeout_end", 8'h00, 1'b0, 1'b0, 8'h00);
`endif
  endtask

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    test_reset();
    test_make_break();
    test_typematic();
    test_extended();
    test_back_to_back();
    test_count_wrap();
    test_reset_mid_prefix();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
